multicycle_control_fsm: RTL and testbench

//  Multi-cycle control sequencer for the MIPS datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_control_fsm.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB
// with bounded memory waits and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int TIMEOUT  = 255,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                branch_en,
  output logic                branch_ne,
  output logic                alu_src,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_io_to_reg,
  output logic                jal,
  output logic                illegal,
  output logic                bus_err,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [5:0]            op_q;
  logic [5:0]            fn_q;
  logic [CW-1:0]         cnt_q;
  logic [RETIRE_W-1:0]   ret_q;
  logic                  tmo;
  logic                  retire;

  // DECODE looks at the live IR fields; later states use the latched copy
  logic d_j, d_jal, d_jr, d_exec;
  logic e_br, e_mem, e_r, e_alui;

  assign tmo = (cnt_q == TMO);

  assign d_j    = (opcode == OP_J);
  assign d_jal  = (opcode == OP_JAL);
  assign d_jr   = (opcode == OP_R) && (funct == FN_JR);
  assign d_exec = !d_jr &&
                  ((opcode == OP_R) ||
                   (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                   (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode[5:3] == 3'b001));

  assign e_br   = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign e_mem  = (op_q == OP_LW) || (op_q == OP_SW);
  assign e_r    = (op_q == OP_R) && (fn_q != FN_JR);
  assign e_alui = (op_q[5:3] == 3'b001);

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    branch_en     = 1'b0;
    branch_ne     = 1'b0;
    alu_src       = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_io_to_reg = 1'b0;
    jal           = 1'b0;
    illegal       = 1'b0;
    bus_err       = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (tmo) begin
          bus_err = 1'b1;
        end
      end
      DECODE: begin
        state_d = FETCH;
        unique case (1'b1)
          d_j: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
          d_jal: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            jal      = 1'b1;
          end
          d_jr: begin
            pc_write = 1'b1;
            pc_src   = 2'd3;
          end
          d_exec: state_d = EXEC;
          default: illegal = 1'b1;
        endcase
      end
      EXEC: begin
        state_d = FETCH;
        unique case (1'b1)
          e_br: begin
            branch_en = 1'b1;
            pc_src    = 2'd1;
            branch_ne = (op_q == OP_BNE);
          end
          e_mem: begin
            alu_src = 1'b1;
            state_d = MEM;
          end
          e_r: state_d = WB;
          e_alui: begin
            alu_src = 1'b1;
            state_d = WB;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
        if (dmem_ready) begin
          state_d = (op_q == OP_SW) ? FETCH : WB;
        end else if (tmo) begin
          bus_err = 1'b1;
          state_d = FETCH;
        end
      end
      WB: begin
        reg_write     = 1'b1;
        reg_dst       = (op_q == OP_R);
        mem_io_to_reg = (op_q == OP_LW);
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign retire = (state_d == FETCH) && (state_q != FETCH) &&
                  !illegal && !bus_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if ((state_d != state_q) || bus_err)
        cnt_q <= '0;
      else if ((state_q == FETCH) || (state_q == MEM))
        cnt_q <= cnt_q + 1'b1;
      if (retire)
        ret_q <= ret_q + 1'b1;
    end
  end

  assign state   = state_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed per-cycle vector bench for multicycle_control_fsm
// (TIMEOUT=4) plus an async-reset-during-WB sequence.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        branch_en, branch_ne, alu_src;
  logic        dmem_req, dmem_we, reg_write, reg_dst;
  logic        mem_io_to_reg, jal, illegal, bus_err;
  logic [2:0]  state;
  logic [31:0] retired;

  multicycle_control_fsm #(.TIMEOUT(4), .RETIRE_W(32)) dut (
    .clk(clk), .rst(rst),
    .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .branch_en(branch_en), .branch_ne(branch_ne),
    .alu_src(alu_src), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_io_to_reg(mem_io_to_reg),
    .jal(jal), .illegal(illegal), .bus_err(bus_err),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] IMQ = 17'h10000;
  localparam logic [16:0] IRW = 17'h08000;
  localparam logic [16:0] PCW = 17'h04000;
  localparam logic [16:0] PSB = 17'h01000;
  localparam logic [16:0] PSJ = 17'h02000;
  localparam logic [16:0] PSR = 17'h03000;
  localparam logic [16:0] BEN = 17'h00800;
  localparam logic [16:0] BNE = 17'h00400;
  localparam logic [16:0] ALS = 17'h00200;
  localparam logic [16:0] DRQ = 17'h00100;
  localparam logic [16:0] DWE = 17'h00080;
  localparam logic [16:0] RW  = 17'h00040;
  localparam logic [16:0] RD  = 17'h00020;
  localparam logic [16:0] M2R = 17'h00010;
  localparam logic [16:0] JAL = 17'h00008;
  localparam logic [16:0] ILL = 17'h00004;
  localparam logic [16:0] BER = 17'h00002;
  localparam logic [16:0] FT  = IMQ | IRW | PCW;

  typedef struct {
    logic        r;
    logic        imr;
    logic        dmr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [2:0]  st;
    logic [16:0] out;
    int          ret;
  } vec_t;

  vec_t v[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [16:0] outs();
    return {imem_req, ir_write, pc_write, pc_src,
            branch_en, branch_ne, alu_src, dmem_req,
            dmem_we, reg_write, reg_dst, mem_io_to_reg,
            jal, illegal, bus_err, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  task automatic add(input logic r, input logic imr,
                     input logic dmr, input logic [5:0] op,
                     input logic [5:0] fn, input logic [2:0] st,
                     input logic [16:0] out, input int ret);
    vec_t e;
    e.r = r; e.imr = imr; e.dmr = dmr; e.op = op;
    e.fn = fn; e.st = st; e.out = out; e.ret = ret;
    v.push_back(e);
  endtask

  initial begin
    // reset, then addu with both ready tied high
    add(0, 0, 0, 6'h00, 6'h00, 0, IMQ, 0);
    add(1, 0, 0, 6'h00, 6'h00, 0, IMQ, 0);
    add(1, 1, 1, 6'h00, 6'h21, 0, FT, 0);
    add(1, 1, 1, 6'h00, 6'h21, 1, 0, 0);
    add(1, 1, 1, 6'h00, 6'h21, 2, 0, 0);
    add(1, 1, 1, 6'h00, 6'h21, 4, RW | RD, 0);
    // lw with dmem_ready three cycles late
    add(1, 1, 1, 6'h23, 6'h00, 0, FT, 1);
    add(1, 1, 1, 6'h23, 6'h00, 1, 0, 1);
    add(1, 1, 0, 6'h23, 6'h00, 2, ALS, 1);
    add(1, 1, 0, 6'h23, 6'h00, 3, DRQ, 1);
    add(1, 1, 0, 6'h23, 6'h00, 3, DRQ, 1);
    add(1, 1, 0, 6'h23, 6'h00, 3, DRQ, 1);
    add(1, 1, 1, 6'h23, 6'h00, 3, DRQ, 1);
    add(1, 1, 1, 6'h23, 6'h00, 4, RW | M2R, 1);
    // jal, bne, illegal
    add(1, 1, 0, 6'h03, 6'h00, 0, FT, 2);
    add(1, 1, 0, 6'h03, 6'h00, 1, PCW | PSJ | JAL, 2);
    add(1, 1, 0, 6'h05, 6'h00, 0, FT, 3);
    add(1, 1, 0, 6'h05, 6'h00, 1, 0, 3);
    add(1, 1, 0, 6'h05, 6'h00, 2, BEN | BNE | PSB, 3);
    add(1, 1, 0, 6'h3f, 6'h00, 0, FT, 4);
    add(1, 1, 0, 6'h3f, 6'h00, 1, ILL, 4);
    // fetch timeout, then ready exactly at the timeout count
    for (int k = 0; k < 4; k++)
      add(1, 0, 0, 6'h3f, 6'h00, 0, IMQ, 4);
    add(1, 0, 0, 6'h3f, 6'h00, 0, IMQ | BER, 4);
    for (int k = 0; k < 4; k++)
      add(1, 0, 0, 6'h2b, 6'h00, 0, IMQ, 4);
    add(1, 1, 0, 6'h2b, 6'h00, 0, FT, 4);
    // sw interrupted by reset in MEM
    add(1, 1, 0, 6'h2b, 6'h00, 1, 0, 4);
    add(1, 1, 0, 6'h2b, 6'h00, 2, ALS, 4);
    add(1, 1, 0, 6'h2b, 6'h00, 3, DRQ | DWE, 4);
    add(0, 0, 0, 6'h2b, 6'h00, 0, IMQ, 0);
    // jr, addi, sw, beq
    add(1, 1, 0, 6'h00, 6'h08, 0, FT, 0);
    add(1, 1, 0, 6'h00, 6'h08, 1, PCW | PSR, 0);
    add(1, 1, 0, 6'h08, 6'h00, 0, FT, 1);
    add(1, 1, 0, 6'h08, 6'h00, 1, 0, 1);
    add(1, 1, 0, 6'h08, 6'h00, 2, ALS, 1);
    add(1, 1, 0, 6'h08, 6'h00, 4, RW, 1);
    add(1, 1, 1, 6'h2b, 6'h00, 0, FT, 2);
    add(1, 1, 1, 6'h2b, 6'h00, 1, 0, 2);
    add(1, 1, 1, 6'h2b, 6'h00, 2, ALS, 2);
    add(1, 1, 1, 6'h2b, 6'h00, 3, DRQ | DWE, 2);
    add(1, 1, 0, 6'h04, 6'h00, 0, FT, 3);
    add(1, 1, 0, 6'h04, 6'h00, 1, 0, 3);
    add(1, 1, 0, 6'h04, 6'h00, 2, BEN | PSB, 3);
    // lw whose data memory never answers
    add(1, 1, 0, 6'h23, 6'h00, 0, FT, 4);
    add(1, 1, 0, 6'h23, 6'h00, 1, 0, 4);
    add(1, 1, 0, 6'h23, 6'h00, 2, ALS, 4);
    for (int k = 0; k < 4; k++)
      add(1, 0, 0, 6'h23, 6'h00, 3, DRQ, 4);
    add(1, 0, 0, 6'h23, 6'h00, 3, DRQ | BER, 4);
    add(1, 0, 0, 6'h23, 6'h00, 0, IMQ, 4);

    foreach (v[i]) begin
      @(negedge clk);
      rst        = v[i].r;
      imem_ready = v[i].imr;
      dmem_ready = v[i].dmr;
      opcode     = v[i].op;
      funct      = v[i].fn;
      #1;
      chk($sformatf("row%0d.state", i), 32'(state), 32'(v[i].st));
      chk($sformatf("row%0d.outs", i), 32'(outs()), 32'(v[i].out));
      chk($sformatf("row%0d.retired", i), retired, v[i].ret);
      chk($sformatf("row%0d.excl", i), 32'(reg_write & jal), 32'd0);
    end

    // async reset landing mid-WB kills reg_write at once
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0;
    #1;
    rst = 1'b1;
    opcode = 6'h00;
    funct = 6'h21;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("wb.state", 32'(state), 32'd4);
    chk("wb.reg_write", 32'(reg_write), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst.reg_write", 32'(reg_write), 32'd0);
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.retired", retired, 32'd0);
    chk("rst.imem_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
